// File: rtl/inst_line_buffer.sv
// Line-at-a-time instruction queue: unpacks a returned cache line from its fetch offset and issues one instruction per cycle.
// Line is dequeueable the cycle after accept; a new line is requested only with a full line of free space reserved.
module inst_line_buffer #(
  parameter int INST_WIDTH = 32,
  parameter int LINE_INSTS = 16,
  parameter int DEPTH      = 32,
  parameter int OFF_W      = $clog2(LINE_INSTS),
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fetch_en,
  output logic                             fetch_req,
  input  logic                             line_valid,
  input  logic [INST_WIDTH*LINE_INSTS-1:0] line_data,
  input  logic [OFF_W-1:0]                 line_offset,
  output logic                             line_ready,
  output logic                             deq_valid,
  output logic [INST_WIDTH-1:0]            deq_data,
  input  logic                             deq_ready,
  input  logic                             flush,
  output logic [CNT_W-1:0]                 count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                state, state_nxt;
  logic [INST_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      free, n_ins;
  logic                  enq, deq;

  // Free space deliberately ignores a same-cycle dequeue so the request decision stays off the consumer path.
  assign free      = CNT_W'(DEPTH) - count;
  assign n_ins     = CNT_W'(LINE_INSTS) - CNT_W'(line_offset);
  assign deq_valid = (count != '0);
  assign deq_data  = deq_valid ? mem[rd_ptr] : '0;
  assign deq       = deq_valid && deq_ready && !flush;

  always_comb begin
    state_nxt  = state;
    fetch_req  = 1'b0;
    line_ready = 1'b0;
    enq        = 1'b0;
    case (state)
      IDLE: begin
        fetch_req = rst_n && fetch_en && !flush && (free >= CNT_W'(LINE_INSTS));
        if (fetch_req) state_nxt = WAIT;
      end
      WAIT: begin
        line_ready = 1'b1;
        if (line_valid) begin
          enq       = !flush;
          state_nxt = IDLE;
        end else if (flush) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        // The stale line from before the redirect is swallowed here.
        line_ready = 1'b1;
        if (line_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (deq) rd_ptr <= rd_ptr + 1'b1;
        if (enq) wr_ptr <= wr_ptr + PTR_W'(n_ins);
        count <= count + (enq ? n_ins : '0) - (deq ? CNT_W'(1) : '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      for (int i = 0; i < LINE_INSTS; i++) begin
        if (i >= int'(line_offset))
          mem[wr_ptr + PTR_W'(i) - PTR_W'(line_offset)] <= line_data[i*INST_WIDTH +: INST_WIDTH];
      end
    end
  end

endmodule

// File: doc/inst_line_buffer.md
Name: inst_line_buffer

Overview:
- Parametrised instruction buffer between the I-cache/arbiter line return and decode.
- Requests one cache line at a time and unpacks it in a single cycle, skipping instructions before the fetch offset.
- Holds instructions in a circular queue and presents them one per cycle on a valid/ready dequeue port.
- Supports flush with discard of an in-flight stale line.

Parameters:
- INST_WIDTH, 32, bits per instruction.
- LINE_INSTS, 16, instructions per returned line; power of 2, >= 2.
- DEPTH, 32, queue entries; power of 2, >= LINE_INSTS.
- OFF_W, $clog2(LINE_INSTS), width of line_offset.
- CNT_W, $clog2(DEPTH)+1, width of count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  frontend permits new line requests.
- fetch_req  out  1  one-cycle pulse requesting the next line.
- line_valid  in  1  returned line present.
- line_data  in  INST_WIDTH*LINE_INSTS  instruction i at bits [i*INST_WIDTH +: INST_WIDTH].
- line_offset  in  OFF_W  index of first useful instruction in the line.
- line_ready  out  1  buffer accepts line this cycle.
- deq_valid  out  1  head instruction available.
- deq_data  out  INST_WIDTH  head instruction.
- deq_ready  in  1  consumer takes head.
- flush  in  1  synchronous clear (redirect).
- count  out  CNT_W  current occupancy.

Behaviour:
- Reset (async, rst_n=0): rd_ptr=wr_ptr=0, count=0, state=IDLE, fetch_req=0, line_ready=0, deq_valid=0, deq_data=0. Storage array is not reset.
- Queue is circular, DEPTH entries. Pointers wrap modulo DEPTH. count is registered and never exceeds DEPTH.
- deq_valid = (count != 0). deq_data = mem[rd_ptr] combinationally (first-word fall-through); deq_data = 0 when empty.
- Dequeue happens when deq_valid && deq_ready: rd_ptr+1, count-1. deq_ready while empty has no effect.
- Enqueue happens when line_valid && line_ready in state WAIT:
  - n = LINE_INSTS - line_offset entries are written.
  - Entries are instructions line_offset..LINE_INSTS-1, stored at wr_ptr, wr_ptr+1, ... with wrap.
  - wr_ptr += n.
- Same-cycle enqueue and dequeue: count_next = count + n - 1. Both pointers update.
- free = DEPTH - count, from registered count only; a same-cycle dequeue is not credited.
- Request FSM, states IDLE, WAIT, DROP:
  - IDLE: fetch_req = fetch_en && !flush && free >= LINE_INSTS. A pulse moves to WAIT next cycle. line_ready=0; line_valid is ignored.
  - WAIT: line_ready=1. Space was reserved at request time, so an accept can never overflow. Accept -> IDLE. fetch_req=0.
  - WAIT with flush and no line_valid -> DROP.
  - WAIT with flush and line_valid in the same cycle: line discarded (nothing written), -> IDLE.
  - DROP: line_ready=1; next line_valid is consumed and discarded, -> IDLE. flush in DROP stays DROP.
  - At most one request outstanding at any time.
- flush (any state):
  - Next cycle: rd_ptr=wr_ptr=0, count=0.
  - Enqueue and dequeue in the flush cycle are cancelled.
  - fetch_req held 0 in the flush cycle.
  - State transitions as above; flush in IDLE stays IDLE.
- rst_n deasserted mid-line: everything returns to reset values immediately. A later line_valid arrives in IDLE and is ignored.
- No combinational path from line_valid to fetch_req. line_ready depends only on state.

Test Plan:
- Reset, fetch_en=1, empty buffer -> fetch_req pulses exactly one cycle after reset release. Return line with instruction words 0x100+i, offset 0 -> count=16; 16 dequeues with deq_ready=1 yield 0x100..0x10F in order, then deq_valid=0.
- Offset 5 line -> count=11. First deq_data = word 5, last = word 15.
- Fill to count=17 with DEPTH=32 -> fetch_req stays 0. Dequeue one (count=16) -> fetch_req pulses next cycle.
- Wrap: wr_ptr=24 when a full line arrives -> entries written at 24..31 and 0..7; order preserved across the wrap on dequeue.
- Simultaneous accept of a 16-instruction line with a dequeue at count=10 -> count=25 next cycle.
- Flush while WAIT, line returns 3 cycles later -> line consumed, count stays 0, state IDLE, then a new fetch_req. Flush coincident with line_valid -> line discarded, IDLE, count=0.
